// File: rtl/and_gate.sv
// and_gate: bitwise two-input AND cell.
//
// Provides a zero-latency combinational result (y) plus a registered,
// valid-qualified copy (y_q) with per-bit edge flags (rise/fall) and
// reduction summaries (all_ones, any_one, ones_cnt) that always describe
// the current registered result.
//
// Optional feature macro: AND_GATE_STATS_EN
//   When defined, adds the hit_cnt port: a saturating count of captures
//   whose result was all ones. When undefined, the port and its logic
//   are absent and everything else behaves identically.
//
// Reset is synchronous and active-low (rst_n sampled on rising clk).

module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             y,
    output logic [WIDTH-1:0]             y_q,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall,
    output logic                         all_ones,
    output logic                         any_one,
    output logic [$clog2(WIDTH+1)-1:0]   ones_cnt
`ifdef AND_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0]             hit_cnt
`endif
);

    // Width of the popcount; holds values 0..WIDTH inclusive.
    localparam int OW = $clog2(WIDTH + 1);

    // Unsigned popcount of a result vector.
    function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + OW'(v[i]);
        end
        return c;
    endfunction

    // Combinational AND, also the value captured by the registered path.
    logic [WIDTH-1:0] and_res;

    // Registered state and its next-state values.
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             all_ones_q, all_ones_d;
    logic             any_one_q, any_one_d;
    logic [OW-1:0]    ones_cnt_q, ones_cnt_d;

    // Zero-latency bitwise AND; independent of clock, reset and valid.
    always_comb begin
        and_res = a & b;
    end

    // Next-state logic: capture on in_valid, otherwise hold the result and
    // clear the one-cycle qualifiers. Summaries follow the next result so
    // they always describe whatever sits in the result register.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        rise_d   = '0;
        fall_d   = '0;
        if (in_valid) begin
            result_d = and_res;
            valid_d  = 1'b1;
            rise_d   = and_res & ~result_q;
            fall_d   = ~and_res & result_q;
        end
        all_ones_d = &result_d;
        any_one_d  = |result_d;
        ones_cnt_d = popcount(result_d);
    end

    // Registered path with synchronous active-low reset taking priority.
    // Clearing the result on reset makes the first capture afterwards
    // compute its edge flags against zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            valid_q    <= 1'b0;
            rise_q     <= '0;
            fall_q     <= '0;
            all_ones_q <= 1'b0;
            any_one_q  <= 1'b0;
            ones_cnt_q <= '0;
        end else begin
            result_q   <= result_d;
            valid_q    <= valid_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            all_ones_q <= all_ones_d;
            any_one_q  <= any_one_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign y         = and_res;
    assign y_q       = result_q;
    assign out_valid = valid_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign all_ones  = all_ones_q;
    assign any_one   = any_one_q;
    assign ones_cnt  = ones_cnt_q;

`ifdef AND_GATE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // Count all-ones captures, pinning at the maximum instead of wrapping.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (in_valid && (&and_res) && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    // Statistics register, cleared by the same synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    // CNT_W only sizes the statistics counter; keep it referenced so the
    // parameter list stays identical between the two builds.
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed self-checking bench for and_gate.
// A WIDTH=1 instance covers the plain 2-input truth table; a WIDTH=8
// instance (CNT_W=2) covers reset, capture, edge flags, hold, back-to-back
// captures and, when AND_GATE_STATS_EN is defined, the saturating counter.

module tb_and_gate;

    logic       clk;
    logic       rst_n;
    logic       in_valid;

    // WIDTH=1 instance signals
    logic [0:0] a1, b1, y1, y_q1, rise1, fall1;
    logic       out_valid1, all_ones1, any_one1;
    logic [0:0] ones_cnt1;

    // WIDTH=8 instance signals
    logic [7:0] a8, b8, y8, y_q8, rise8, fall8;
    logic       out_valid8, all_ones8, any_one8;
    logic [3:0] ones_cnt8;
`ifdef AND_GATE_STATS_EN
    logic [1:0] hit_cnt1_unused;
    logic [1:0] hit_cnt8;
`endif

    int total  = 0;
    int passed = 0;

    and_gate #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (in_valid),
        .y         (y1),
        .y_q       (y_q1),
        .out_valid (out_valid1),
        .rise      (rise1),
        .fall      (fall1),
        .all_ones  (all_ones1),
        .any_one   (any_one1),
        .ones_cnt  (ones_cnt1)
`ifdef AND_GATE_STATS_EN
        ,
        .hit_cnt   (hit_cnt1_unused)
`endif
    );

    and_gate #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .in_valid  (in_valid),
        .y         (y8),
        .y_q       (y_q8),
        .out_valid (out_valid8),
        .rise      (rise8),
        .fall      (fall8),
        .all_ones  (all_ones8),
        .any_one   (any_one8),
        .ones_cnt  (ones_cnt8)
`ifdef AND_GATE_STATS_EN
        ,
        .hit_cnt   (hit_cnt8)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Drive the WIDTH=8 operands and the shared valid.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic vld);
        a8       = av;
        b8       = bv;
        in_valid = vld;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;

        // WIDTH=1 truth table, purely combinational, 10-unit steps.
        a1 = 1'b0; b1 = 1'b0; #1; checkOutput("tt_00", 64'(y1), 64'h0); #9;
        a1 = 1'b0; b1 = 1'b1; #1; checkOutput("tt_01", 64'(y1), 64'h0); #9;
        a1 = 1'b1; b1 = 1'b0; #1; checkOutput("tt_10", 64'(y1), 64'h0); #9;
        a1 = 1'b1; b1 = 1'b1; #1; checkOutput("tt_11", 64'(y1), 64'h1); #9;

        // Reset held for two clocks with valid all-ones inputs.
        rst_n = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        tick(); tick();
        checkOutput("rst_y8",        64'(y8), 64'hFF);
        checkOutput("rst_y1",        64'(y1), 64'h1);
        checkOutput("rst_y_q",       64'(y_q8), 64'h0);
        checkOutput("rst_out_valid", 64'(out_valid8), 64'h0);
        checkOutput("rst_all_ones",  64'(all_ones8), 64'h0);
        checkOutput("rst_any_one",   64'(any_one8), 64'h0);
        checkOutput("rst_ones_cnt",  64'(ones_cnt8), 64'h0);
        checkOutput("rst_rise",      64'(rise8), 64'h0);
        checkOutput("rst_fall",      64'(fall8), 64'h0);
        checkOutput("rst_y_q1",      64'(y_q1), 64'h0);
`ifdef AND_GATE_STATS_EN
        checkOutput("rst_hit_cnt",   64'(hit_cnt8), 64'h0);
`endif

        // Release reset with valid low; nothing is captured.
        rst_n = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("idle_y_q", 64'(y_q8), 64'h0);

        // Single capture F0 & 3C = 30.
        applyStimulus(8'hF0, 8'h3C, 1'b1);
        tick();
        checkOutput("cap_y_q",       64'(y_q8), 64'h30);
        checkOutput("cap_out_valid", 64'(out_valid8), 64'h1);
        checkOutput("cap_ones_cnt",  64'(ones_cnt8), 64'h2);
        checkOutput("cap_any_one",   64'(any_one8), 64'h1);
        checkOutput("cap_all_ones",  64'(all_ones8), 64'h0);
        checkOutput("cap_rise",      64'(rise8), 64'h30);
        checkOutput("cap_fall",      64'(fall8), 64'h0);
        in_valid = 1'b0;
        tick();
        checkOutput("cap_idle_out_valid", 64'(out_valid8), 64'h0);
        checkOutput("cap_idle_y_q",       64'(y_q8), 64'h30);
        checkOutput("cap_idle_rise",      64'(rise8), 64'h0);

        // Edge flags: FF then 0F.
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        tick();
        checkOutput("edge1_y_q",      64'(y_q8), 64'hFF);
        checkOutput("edge1_all_ones", 64'(all_ones8), 64'h1);
        checkOutput("edge1_rise",     64'(rise8), 64'hCF);
        checkOutput("edge1_ones_cnt", 64'(ones_cnt8), 64'h8);
        applyStimulus(8'h0F, 8'hFF, 1'b1);
        tick();
        checkOutput("edge2_y_q",      64'(y_q8), 64'h0F);
        checkOutput("edge2_fall",     64'(fall8), 64'hF0);
        checkOutput("edge2_rise",     64'(rise8), 64'h00);
        checkOutput("edge2_all_ones", 64'(all_ones8), 64'h0);
        checkOutput("edge2_ones_cnt", 64'(ones_cnt8), 64'h4);

        // Hold: valid low while operands toggle.
        applyStimulus(8'hAA, 8'hCC, 1'b0);
        #1;
        checkOutput("hold_y_a", 64'(y8), 64'h88);
        tick();
        checkOutput("hold_y_q_a",      64'(y_q8), 64'h0F);
        checkOutput("hold_out_valid",  64'(out_valid8), 64'h0);
        checkOutput("hold_fall",       64'(fall8), 64'h0);
        applyStimulus(8'h55, 8'hFF, 1'b0);
        #1;
        checkOutput("hold_y_b", 64'(y8), 64'h55);
        tick();
        checkOutput("hold_y_q_b",     64'(y_q8), 64'h0F);
        checkOutput("hold_ones_cnt",  64'(ones_cnt8), 64'h4);

        // Mid-stream reset: next capture measures edges against zero.
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_y_q", 64'(y_q8), 64'h0);
        rst_n = 1'b1;
        applyStimulus(8'h0F, 8'hFF, 1'b1);
        tick();
        checkOutput("mid_rst_rise", 64'(rise8), 64'h0F);
        checkOutput("mid_rst_fall", 64'(fall8), 64'h0);

        // Back-to-back all-ones captures after a fresh reset.
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        begin
            logic [1:0] exp_hits [5];
            exp_hits = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 5; i++) begin
                tick();
                checkOutput($sformatf("b2b_out_valid_%0d", i), 64'(out_valid8), 64'h1);
                checkOutput($sformatf("b2b_rise_%0d", i), 64'(rise8), (i == 0) ? 64'hFF : 64'h0);
`ifdef AND_GATE_STATS_EN
                checkOutput($sformatf("hit_cnt_%0d", i), 64'(hit_cnt8), 64'(exp_hits[i]));
`else
                checkOutput($sformatf("b2b_y_q_%0d", i), 64'(y_q8), 64'(8'hFF) + 64'(exp_hits[i]) * 0);
`endif
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("final_rst_y_q", 64'(y_q8), 64'h0);
`ifdef AND_GATE_STATS_EN
        checkOutput("final_rst_hit_cnt", 64'(hit_cnt8), 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
